// File: rtl/lcd_framebuffer_if.sv
// Host write stream and LCD driver read port of the framebuffer.
// The block side connects through the slave modport, the host/driver side through master.
interface lcd_framebuffer_if;
    logic [7:0] x;
    logic [3:0] y;
    logic [7:0] pixels;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_cmd;
    logic [7:0] wr_data;
    logic       busy;

    modport master (
        output x, y, wr_valid, wr_cmd, wr_data,
        input  pixels, wr_ready, busy
    );

    modport slave (
        input  x, y, wr_valid, wr_cmd, wr_data,
        output pixels, wr_ready, busy
    );
endinterface

// File: rtl/lcd_framebuffer.sv
// Page/column organised display memory with a host byte/command stream,
// a registered read port for the LCD driver and an automatic clear after reset.
module lcd_framebuffer #(
    parameter int unsigned WIDTH     = 250,
    parameter int unsigned PAGES     = 8,
    parameter int unsigned ADDR_BITS = 11
) (
    input logic           clk,
    input logic           reset,
    lcd_framebuffer_if.slave bus
);

    localparam int unsigned          MEM_DEPTH = WIDTH * PAGES;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MEM_DEPTH - 1);
    localparam logic [7:0]           LAST_COL  = 8'(WIDTH - 1);
    localparam logic [8:0]           WIDTH_9   = 9'(WIDTH);

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_SET_COL = 8'h02;
    localparam logic [4:0] CMD_SET_PG  = 5'b0_0010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COLARG = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t                 state;
    logic [7:0]             cur_col;
    logic [2:0]             cur_page;
    logic [ADDR_BITS-1:0]   clr_addr;
    logic [7:0]             mem [MEM_DEPTH];

    logic                   accept_c;
    logic                   we_c;
    logic [ADDR_BITS-1:0]   waddr_c;
    logic [7:0]             wdata_c;
    logic [ADDR_BITS-1:0]   raddr_c;
    logic                   unused_y3;

    // Row-major page/column to linear byte address.
    function automatic logic [ADDR_BITS-1:0] addr_of(input logic [2:0] page,
                                                    input logic [7:0] col);
        return ADDR_BITS'(page) * ADDR_BITS'(WIDTH) + ADDR_BITS'(col);
    endfunction

    assign unused_y3 = bus.y[3];
    assign accept_c  = bus.wr_valid && bus.wr_ready;
    assign raddr_c   = addr_of(bus.y[2:0], bus.x);

    // Single write port shared between the clear sweep and host data bytes.
    always_comb begin
        we_c    = 1'b0;
        waddr_c = '0;
        wdata_c = '0;
        if (state == CLEAR) begin
            we_c    = 1'b1;
            waddr_c = clr_addr;
        end else if (state == IDLE && accept_c && !bus.wr_cmd) begin
            we_c    = 1'b1;
            waddr_c = addr_of(cur_page, cur_col);
            wdata_c = bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[waddr_c] <= wdata_c;
        end
    end

    // Read register samples the array before any same-edge write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.pixels <= 8'h00;
        end else if (9'(bus.x) >= WIDTH_9) begin
            bus.pixels <= 8'h00;
        end else begin
            bus.pixels <= mem[raddr_c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= CLEAR;
            clr_addr     <= '0;
            cur_col      <= '0;
            cur_page     <= '0;
            bus.wr_ready <= 1'b0;
            bus.busy     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if (!bus.wr_cmd) begin
                            if (cur_col == LAST_COL) begin
                                cur_col  <= '0;
                                cur_page <= cur_page + 3'd1;
                            end else begin
                                cur_col <= cur_col + 8'd1;
                            end
                        end else if (bus.wr_data == CMD_CLEAR) begin
                            state        <= CLEAR;
                            bus.wr_ready <= 1'b0;
                            bus.busy     <= 1'b1;
                        end else if (bus.wr_data[7:3] == CMD_SET_PG) begin
                            cur_page <= bus.wr_data[2:0];
                            cur_col  <= '0;
                        end else if (bus.wr_data == CMD_SET_COL) begin
                            state <= COLARG;
                        end
                    end
                end
                COLARG: begin
                    // Argument byte is taken whatever wr_cmd says; out-of-range clamps.
                    if (accept_c) begin
                        cur_col <= (9'(bus.wr_data) > 9'(LAST_COL)) ? LAST_COL : bus.wr_data;
                        state   <= IDLE;
                    end
                end
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        clr_addr     <= '0;
                        cur_col      <= '0;
                        cur_page     <= '0;
                        state        <= IDLE;
                        bus.wr_ready <= 1'b1;
                        bus.busy     <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + ADDR_BITS'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.wr_ready <= 1'b1;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_framebuffer.md
# lcd_framebuffer

Byte-organised display memory that sits directly upstream of the LCD panel driver. It answers the driver's `x`/`y` read requests with the 8-pixel column byte for that position. It also accepts a byte stream from the host side (data bytes plus a small command set) through a valid/ready handshake. Memory covers 250 columns × 8 pages (2000 bytes) and is cleared automatically after reset.

## Interface

Parameters:
- `WIDTH`, 250, columns per page; legal column range is 0..WIDTH-1.
- `PAGES`, 8, pages of 8 pixel rows each; must be 8, page index is 3 bits.
- `ADDR_BITS`, 11, memory address width; must satisfy 2^ADDR_BITS ≥ WIDTH*PAGES.

Ports:
- `clk`  input  1  single clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `x`  input  8  read column, driven by the LCD driver.
- `y`  input  4  read page, driven by the LCD driver; only `y[2:0]` is used, `y[3]` is ignored.
- `pixels`  output  8  registered read data for (`x`,`y`); bit 0 is the top pixel row of the page.
- `wr_valid`  input  1  host byte is present.
- `wr_ready`  output  1  block can accept a byte this cycle.
- `wr_cmd`  input  1  1 = `wr_data` is a command, 0 = pixel data.
- `wr_data`  input  8  command or pixel byte.
- `busy`  output  1  high while a clear is in progress.

## Operation

- Storage: address = `y[2:0]`*WIDTH + column, so the range is 0..1999. Memory is not reset; its contents are defined only by a clear.
- Transfer: a byte transfers on a rising edge where `wr_valid` && `wr_ready`. `wr_data`/`wr_cmd` are ignored on other edges.
- Cursor: `cur_col` is 8 bits and `cur_page` is 3 bits.
- State machine states: IDLE, COLARG, CLEAR.
- IDLE, data byte (`wr_cmd`=0): writes `wr_data` to (`cur_col`,`cur_page`), then advances the cursor.
  - Column auto-increments.
  - At `cur_col`==WIDTH-1 the column wraps to 0 and the page increments.
  - Page 7 wraps to page 0.
- IDLE, command byte (`wr_cmd`=1):
  - 8'h01 CLEAR: go to CLEAR.
  - 8'b0001_0ppp SET_PAGE: `cur_page`←ppp, `cur_col`←0.
  - 8'h02 SET_COL: go to COLARG.
  - Any other code: ignored, stay in IDLE.
- COLARG: the next transferred byte is the column argument regardless of `wr_cmd`.
  - `cur_col`←min(`wr_data`, WIDTH-1); page is unchanged.
  - Return to IDLE.
- CLEAR: writes 8'h00 to address `clr_addr` each cycle, with `clr_addr` running 0..WIDTH*PAGES-1.
  - After the write to the last address: cursor←(0,0), `clr_addr`←0, go to IDLE.
  - `wr_ready`=0 and `busy`=1 for the whole CLEAR state.
- Read port:
  - `pixels` ← mem[addr(`x`,`y`)] every cycle.
  - If `x`≥WIDTH, `pixels` ← 8'h00 instead.
  - Reads are never stalled by writes or by CLEAR; during CLEAR a read returns whatever the memory currently holds.
- Read/write collision at the same address in the same cycle: `pixels` returns the old byte (read-before-write).

## Timing

- Reset asserted: state=CLEAR, `clr_addr`=0, `cur_col`=0, `cur_page`=0, `pixels`=8'h00, `wr_ready`=0, `busy`=1.
- The clear therefore starts on the first edge after reset deasserts and lasts exactly 2000 cycles. `wr_ready`=1 and `busy`=0 on the cycle after the write to address 1999.
- Reset asserted mid-clear or mid-COLARG: restarts the full clear from address 0; a pending column argument is discarded.
- `wr_ready` is a registered output: 1 in IDLE and COLARG, 0 in CLEAR. The host may hold `wr_valid` high continuously, giving one byte per cycle.
- A CLEAR command accepted on edge N: `wr_ready` falls after edge N; first clear write on edge N+1; `wr_ready` rises after edge N+2000.
- Write latency: a data byte accepted on edge N is visible on `pixels` after edge N+2, provided `x`/`y` point at that address from edge N+1.
- Read latency is 1 cycle: `x`/`y` sampled on edge N, `pixels` valid after edge N. The LCD driver holds `x`/`y` for many cycles, so no further handshake is needed.
- Address arithmetic is done at ADDR_BITS width, with no overflow inside the legal range.

## Test plan

- Reset release → `wr_ready`=0 for exactly 2000 cycles, then 1. Reading (0,0), (249,7) and (125,3) all return 8'h00.
- After the clear, SET_PAGE 8'h13, then data 8'hA5, 8'h5A → `pixels` is 8'hA5 at (x=0,y=3) and 8'h5A at (x=1,y=3); (2,3) stays 8'h00.
- SET_COL with argument 249 on page 7, then data 8'h11, 8'h22 → 8'h11 at (249,7), 8'h22 at (0,0) (column and page wrap). A SET_COL argument of 255 clamps, so the next data byte lands at column 249.
- Host holds `wr_valid`=1 and sends 2000 data bytes of incrementing values mod 256 → every address holds (address mod 256). Reading x=250 returns 8'h00.
- CLEAR command while `wr_valid` is held high with data 8'hFF → no byte is accepted during the 2000-cycle clear. The first byte after the clear is written to (0,0); all other addresses read 8'h00.
- Reset asserted at clear cycle 1000 after a 0xAB fill → a full 2000-cycle clear restarts and every address reads 8'h00 afterwards. A same-cycle write to the read address returns the old value, then the new value one cycle later.
